lut_ram_mt: RTL and testbench
=============================

Name: lut_ram_mt

Overview:
- Multi-context distributed-RAM register store, the successor to the single-write/single-read LUT RAM.
- Holds NUM_CTX independent banks of 2^ADDR_WIDTH words (one bank per hardware thread).
- Provides one byte-enabled write port, two asynchronous read ports with write-first bypass, and an optional RISC-V x0 hard-zero.
- A sweep FSM re-initialises every entry to INIT_VAL after reset or on request, because LUT RAM has no reset.

Parameters:
- NUM_CTX, 16, number of contexts; power of two, ≥1.
- ADDR_WIDTH, 5, per-context word address width.
- DATA_WIDTH, 32, word width; multiple of 8.
- INIT_VAL, 0, value written by the clear sweep.
- RAM_STYLE_ATTR, "distributed", synthesis ram_style attribute on the array.
- ZERO_ADDR0, 1, if 1, reads of address 0 in any context return 0 and writes to address 0 are dropped.

Ports:
- clka  in  1  clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle pulse; starts a full clear sweep when idle.
- busy  out  1  high while a sweep runs.
- we  in  1  write enable.
- wctx  in  CTX_W  write context; CTX_W = max(1, clog2(NUM_CTX)).
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- wbe  in  DATA_WIDTH/8  byte enables.
- rctx_a  in  CTX_W  read port A context.
- raddr_a  in  ADDR_WIDTH  read port A address.
- rdata_a  out  DATA_WIDTH  read port A data.
- rctx_b  in  CTX_W  read port B context.
- raddr_b  in  ADDR_WIDTH  read port B address.
- rdata_b  out  DATA_WIDTH  read port B data.

Behaviour:
- Storage:
  - Flat address = {ctx, addr}; DEPTH = NUM_CTX * 2^ADDR_WIDTH.
  - Array carries the ram_style attribute and has no reset.
- Write:
  - When we=1 and busy=0, bytes i with wbe[i]=1 are updated at the edge; other bytes are kept.
  - we with wbe=0 is a no-op.
  - With ZERO_ADDR0=1, waddr=0 writes are dropped.
- Read:
  - Combinational, zero latency.
  - If we=1, busy=0 and the read flat address equals the write flat address, the output is the merged word: new bytes where wbe is set, stored bytes elsewhere (write-first).
  - With ZERO_ADDR0=1, raddr=0 returns 0; this overrides the bypass.
  - Ports A and B are independent; both may hit the same address.
- Clear FSM, states IDLE and SWEEP:
  - reset=1 forces state=SWEEP and ptr=0. A reset asserted mid-sweep restarts the sweep at 0.
  - In SWEEP, each cycle writes INIT_VAL to MEM[ptr] on all bytes, then ptr++.
  - At ptr=DEPTH-1 the FSM writes that entry and moves to IDLE on the same edge. A sweep therefore takes exactly DEPTH cycles after reset deasserts.
  - In IDLE, clr_req=1 moves to SWEEP with ptr=0 at the next edge; busy rises the following cycle.
  - clr_req while busy is ignored.
  - clr_req and we together in IDLE: the write is performed, then the sweep overwrites it.
- busy = (state==SWEEP).
  - Reset value of busy is 1; busy stays 1 during reset and through the sweep.
- While busy=1:
  - External writes are ignored (no back-pressure; the caller checks busy).
  - rdata_a and rdata_b are forced to INIT_VAL (0 for address 0 when ZERO_ADDR0=1).
- Reset values: busy=1, rdata_a/rdata_b=INIT_VAL, state=SWEEP, ptr=0.
- ptr width is clog2(DEPTH)+1 so no wrap-around occurs before the terminal compare.

Optional Feature:
- Macro: LUTRAM_OUT_REG_EN.
- Defined:
  - rdata_a and rdata_b are registered, giving one-cycle latency.
  - The register captures the post-bypass, post-zero, post-busy-mask value.
  - reset loads the registers with INIT_VAL.
- Undefined: purely combinational reads as described above.

Decomposition:
- Package lut_ram_mt_pkg holds:
  - typedef enum logic {IDLE, SWEEP} clr_state_t;
  - function merge_bytes(old, new, be) for byte-lane merging.
  - localparam helpers for CTX_W and DEPTH computation.
- One sub-module, lut_ram_mt_rdport, is instantiated twice. It contains the flat-address compare, bypass merge, zero/busy masking and the optional output register.

Test Plan:
- Reset for 2 cycles, then release: busy=1 for exactly 512 cycles (16x32), then 0. Every read of ctx 0..15, addr 1..31 returns INIT_VAL (set INIT_VAL=32'hDEADBEEF).
- Write ctx=3, addr=7, wdata=32'h11223344, wbe=4'hF. Then write the same address with wdata=32'hAABBCCDD, wbe=4'b0101. Port A reading (3,7) returns 32'h11BB33DD.
- Same-cycle bypass: we=1 at (5,9), wdata=32'hCAFEF00D, wbe=4'hF, with port B reading (5,9) → rdata_b=32'hCAFEF00D that cycle. With LUTRAM_OUT_REG_EN defined, the value appears one cycle later.
- Write 32'hFFFFFFFF to (2,0) with ZERO_ADDR0=1 → reads of (2,0) return 0 on both ports. With ZERO_ADDR0=0, reads return 32'hFFFFFFFF.
- Context isolation: write 32'h1 to (0,4) and 32'h2 to (15,4) → A at (0,4)=1 and B at (15,4)=2 simultaneously.
- clr_req after data is loaded, reset asserted mid-sweep at ptr=100, and clr_req pulsed while busy:
  - clr_req after data: busy rises next cycle and every entry returns INIT_VAL after 512 cycles.
  - Reset mid-sweep at ptr=100: busy stays 1 for a full 512 cycles after release.
  - clr_req while busy: no extension of the sweep.

Source files
------------

// File: rtl/lut_ram_mt_pkg.sv
// Shared types and helpers for the multi-context LUT RAM register store.
package lut_ram_mt_pkg;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} clr_state_t;

    // Widest word merge_bytes can handle; callers zero-extend and truncate around it.
    localparam int unsigned MAX_DW = 1024;
    localparam int unsigned MAX_BE = MAX_DW / 8;

    function automatic int unsigned ctx_width(input int unsigned num_ctx);
        return (num_ctx > 1) ? $clog2(num_ctx) : 1;
    endfunction

    function automatic int unsigned depth_of(input int unsigned num_ctx,
                                             input int unsigned addr_width);
        return num_ctx << addr_width;
    endfunction

    function automatic int unsigned flat_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_word,
                                                      input logic [MAX_DW-1:0] new_word,
                                                      input logic [MAX_BE-1:0] be);
        logic [MAX_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/lut_ram_mt_rdport.sv
// One asynchronous read port: flat-address match against the live write, write-first merge,
// zero/busy masking. Defining LUTRAM_OUT_REG_EN registers rdata (one cycle of latency).
module lut_ram_mt_rdport
    import lut_ram_mt_pkg::*;
#(
    parameter int unsigned           CTX_W      = 4,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           FLAT_W     = 9,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter bit                    ZERO_ADDR0 = 1'b1
) (
    input  logic                    clka,
    input  logic                    reset,
    input  logic [CTX_W-1:0]        rctx,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [FLAT_W-1:0]       rflat,
    input  logic [DATA_WIDTH-1:0]   rd_word,
    input  logic                    wr_en,
    input  logic [FLAT_W-1:0]       wflat,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    busy,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic                  hit;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd_val;

    assign rflat  = FLAT_W'({rctx, raddr});
    assign hit    = wr_en && (rflat == wflat);
    assign merged = DATA_WIDTH'(merge_bytes(MAX_DW'(rd_word), MAX_DW'(wdata), MAX_BE'(wbe)));

    // Priority: address-0 zero beats the busy mask, which beats the bypass.
    always_comb begin
        rd_val = hit ? merged : rd_word;
        if (busy) begin
            rd_val = INIT_VAL;
        end
        if (ZERO_ADDR0 && (raddr == '0)) begin
            rd_val = '0;
        end
    end

`ifdef LUTRAM_OUT_REG_EN
    always_ff @(posedge clka) begin
        if (reset) begin
            rdata <= INIT_VAL;
        end else begin
            rdata <= rd_val;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clka ^ reset;
    assign rdata          = rd_val;
`endif

endmodule

// File: rtl/lut_ram_mt.sv
// Multi-context distributed-RAM register store with a clear sweep (LUT RAM has no reset).
// Define LUTRAM_OUT_REG_EN to register both read ports.
module lut_ram_mt
    import lut_ram_mt_pkg::*;
#(
    parameter int unsigned           NUM_CTX        = 16,
    parameter int unsigned           ADDR_WIDTH     = 5,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL       = '0,
    parameter                        RAM_STYLE_ATTR = "distributed",
    parameter bit                    ZERO_ADDR0     = 1'b1,
    localparam int unsigned          CTX_W          = ctx_width(NUM_CTX)
) (
    input  logic                    clka,
    input  logic                    reset,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    we,
    input  logic [CTX_W-1:0]        wctx,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [CTX_W-1:0]        rctx_a,
    input  logic [ADDR_WIDTH-1:0]   raddr_a,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    input  logic [CTX_W-1:0]        rctx_b,
    input  logic [ADDR_WIDTH-1:0]   raddr_b,
    output logic [DATA_WIDTH-1:0]   rdata_b
);

    localparam int unsigned DEPTH  = depth_of(NUM_CTX, ADDR_WIDTH);
    localparam int unsigned FLAT_W = flat_width(DEPTH);
    localparam int unsigned PTR_W  = FLAT_W + 1;
    localparam int unsigned NB     = DATA_WIDTH / 8;

    if (RAM_STYLE_ATTR == 0) begin : g_bad_style
        $error("lut_ram_mt: RAM_STYLE_ATTR must not be empty");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
        $error("lut_ram_mt: DATA_WIDTH must be a multiple of 8 and at most MAX_DW");
    end
    if ((NUM_CTX & (NUM_CTX - 1)) != 0) begin : g_bad_ctx
        $error("lut_ram_mt: NUM_CTX must be a power of two");
    end

    clr_state_t       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sweep_last;
    logic             sweep_we;
    logic             wr_en;
    logic             wr_commit;
    logic [FLAT_W-1:0] wflat;
    logic [FLAT_W-1:0] rflat_a, rflat_b;
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

    (* ram_style = RAM_STYLE_ATTR *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear FSM: state register.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sweep_last = (ptr_q == PTR_W'(DEPTH - 1));

    // Clear FSM: next state. The last entry is written on the edge that returns to IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (sweep_last) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        endcase
    end

    // Clear FSM: outputs.
    always_comb begin
        busy     = (state_q == SWEEP);
        sweep_we = (state_q == SWEEP);
        wr_en    = we && (state_q == IDLE);
    end

    assign wflat     = FLAT_W'({wctx, waddr});
    assign wr_commit = wr_en && (|wbe) && !(ZERO_ADDR0 && (waddr == '0));

    always_ff @(posedge clka) begin
        if (sweep_we) begin
            mem[ptr_q[FLAT_W-1:0]] <= INIT_VAL;
        end else if (wr_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[wflat][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rd_word_a = mem[rflat_a];
    assign rd_word_b = mem[rflat_b];

    lut_ram_mt_rdport #(
        .CTX_W      (CTX_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FLAT_W     (FLAT_W),
        .INIT_VAL   (INIT_VAL),
        .ZERO_ADDR0 (ZERO_ADDR0)
    ) u_rdport_a (
        .clka    (clka),
        .reset   (reset),
        .rctx    (rctx_a),
        .raddr   (raddr_a),
        .rflat   (rflat_a),
        .rd_word (rd_word_a),
        .wr_en   (wr_en),
        .wflat   (wflat),
        .wdata   (wdata),
        .wbe     (wbe),
        .busy    (busy),
        .rdata   (rdata_a)
    );

    lut_ram_mt_rdport #(
        .CTX_W      (CTX_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FLAT_W     (FLAT_W),
        .INIT_VAL   (INIT_VAL),
        .ZERO_ADDR0 (ZERO_ADDR0)
    ) u_rdport_b (
        .clka    (clka),
        .reset   (reset),
        .rctx    (rctx_b),
        .raddr   (raddr_b),
        .rflat   (rflat_b),
        .rd_word (rd_word_b),
        .wr_en   (wr_en),
        .wflat   (wflat),
        .wdata   (wdata),
        .wbe     (wbe),
        .busy    (busy),
        .rdata   (rdata_b)
    );

endmodule

// File: tb/tb_lut_ram_mt.sv
// Scoreboard bench for lut_ram_mt: two instances (address-0 zeroing on and off) share stimulus.
module tb_lut_ram_mt;

    localparam int unsigned DEPTH = 512;
    localparam logic [31:0] INIT  = 32'hDEADBEEF;
`ifdef LUTRAM_OUT_REG_EN
    localparam int unsigned LAT = 1;
`else
    localparam int unsigned LAT = 0;
`endif

    logic        clka = 1'b0;
    logic        reset, clr_req, we;
    logic [3:0]  wctx, rctx_a, rctx_b, wbe;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic        busy_z, busy_n;
    logic [31:0] rdata_a_z, rdata_b_z, rdata_a_n, rdata_b_n;

    always #5 clka = ~clka;

    lut_ram_mt #(
        .NUM_CTX(16), .ADDR_WIDTH(5), .DATA_WIDTH(32), .INIT_VAL(INIT),
        .RAM_STYLE_ATTR("distributed"), .ZERO_ADDR0(1'b1)
    ) u_dut_z (
        .clka(clka), .reset(reset), .clr_req(clr_req), .busy(busy_z),
        .we(we), .wctx(wctx), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rctx_a(rctx_a), .raddr_a(raddr_a), .rdata_a(rdata_a_z),
        .rctx_b(rctx_b), .raddr_b(raddr_b), .rdata_b(rdata_b_z)
    );

    lut_ram_mt #(
        .NUM_CTX(16), .ADDR_WIDTH(5), .DATA_WIDTH(32), .INIT_VAL(INIT),
        .RAM_STYLE_ATTR("distributed"), .ZERO_ADDR0(1'b0)
    ) u_dut_n (
        .clka(clka), .reset(reset), .clr_req(clr_req), .busy(busy_n),
        .we(we), .wctx(wctx), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .rctx_a(rctx_a), .raddr_a(raddr_a), .rdata_a(rdata_a_n),
        .rctx_b(rctx_b), .raddr_b(raddr_b), .rdata_b(rdata_b_n)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model of storage (address 0 kept, as in the non-zeroing instance) and sweep.
    logic [31:0] mem_m [DEPTH];
    bit          sweep_m = 1'b1;
    int unsigned ptr_m   = 0;
    int unsigned cyc     = 0;

    always @(posedge clka) cyc <= cyc + 1;

    function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] v = o;
        for (int i = 0; i < 4; i++) if (be[i]) v[i*8 +: 8] = n[i*8 +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] c, input logic [4:0] a,
                                           input bit zero);
        int unsigned f = {c, a};
        if (zero && a == 5'd0) return 32'h0;
        if (sweep_m) return INIT;
        if (we && f == {wctx, waddr}) return merge_m(mem_m[f], wdata, wbe);
        return mem_m[f];
    endfunction

    task automatic model_edge();
        if (sweep_m) mem_m[ptr_m] = INIT;
        if (reset) begin
            sweep_m = 1'b1;
            ptr_m   = 0;
        end else if (sweep_m) begin
            if (ptr_m == DEPTH - 1) begin
                sweep_m = 1'b0;
                ptr_m   = 0;
            end else begin
                ptr_m++;
            end
        end else begin
            if (we) mem_m[{wctx, waddr}] = merge_m(mem_m[{wctx, waddr}], wdata, wbe);
            if (clr_req) begin
                sweep_m = 1'b1;
                ptr_m   = 0;
            end
        end
    endtask

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] za, zb, na, nb;
    } sb_entry_t;
    sb_entry_t sb[$];
    string     sb_tag[$];

    // One clock cycle with the inputs currently driven; optionally queue expected read data.
    task automatic cycle(input bit rd, input string tag);
        sb_entry_t e;
        if (rd) begin
            e.due = cyc + LAT;
            e.za  = exp_rd(rctx_a, raddr_a, 1'b1);
            e.zb  = exp_rd(rctx_b, raddr_b, 1'b1);
            e.na  = exp_rd(rctx_a, raddr_a, 1'b0);
            e.nb  = exp_rd(rctx_b, raddr_b, 1'b0);
            sb.push_back(e);
            sb_tag.push_back(tag);
        end
        model_edge();
        @(posedge clka);
        #1;
    endtask

    always @(negedge clka) begin
        sb_entry_t e;
        string     t;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, "/a_z"}, rdata_a_z, e.za);
            check({t, "/b_z"}, rdata_b_z, e.zb);
            check({t, "/a_n"}, rdata_a_n, e.na);
            check({t, "/b_n"}, rdata_b_n, e.nb);
        end
    end

    task automatic write(input int unsigned c, input int unsigned a, input logic [31:0] d,
                         input logic [3:0] be);
        we    = 1'b1;
        wctx  = 4'(c);
        waddr = 5'(a);
        wdata = d;
        wbe   = be;
    endtask

    task automatic set_rd(input int unsigned ca, input int unsigned aa, input int unsigned cb,
                          input int unsigned ab);
        rctx_a  = 4'(ca);
        raddr_a = 5'(aa);
        rctx_b  = 4'(cb);
        raddr_b = 5'(ab);
    endtask

    task automatic read_all(input string tag);
        we = 1'b0;
        for (int i = 0; i < DEPTH; i += 2) begin
            {rctx_a, raddr_a} = 9'(i);
            {rctx_b, raddr_b} = 9'(i + 1);
            cycle(1'b1, tag);
        end
    endtask

    // Count busy cycles until idle; optionally pulse clr_req and attempt a write mid-sweep.
    task automatic wait_sweep(input string tag, input int pulse_at, input bit poke);
        int n = 0;
        while (busy_z && n < 2000) begin
            if (n == pulse_at) clr_req = 1'b1;
            if (poke && n == 300) write(0, 5, 32'h5A5A5A5A, 4'hF);
            cycle(1'b0, "");
            clr_req = 1'b0;
            we      = 1'b0;
            n++;
        end
        check({tag, "/busy_cycles"}, 32'(n), 32'(DEPTH));
        check({tag, "/busy_n"}, 32'(busy_n), 32'(sweep_m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clr_req = 1'b0; we = 1'b0;
        wctx = '0; waddr = '0; wdata = '0; wbe = '0;
        set_rd(0, 0, 0, 0);
        cycle(1'b0, "");
        set_rd(1, 3, 0, 0);
        cycle(1'b1, "reset_rd");
        check("reset/busy", 32'(busy_z), 32'd1);
        reset = 1'b0;
        wait_sweep("init", -1, 1'b0);
        read_all("init_all");

        // Byte-enabled update, with port B reading the target during the partial write.
        write(3, 7, 32'h11223344, 4'hF);
        cycle(1'b0, "");
        write(3, 7, 32'hAABBCCDD, 4'b0101);
        set_rd(3, 6, 3, 7);
        cycle(1'b1, "merge_bypass");
        we = 1'b0;
        set_rd(3, 7, 3, 7);
        cycle(1'b1, "merge");

        write(5, 9, 32'hCAFEF00D, 4'hF);
        set_rd(0, 1, 5, 9);
        cycle(1'b1, "bypass");

        write(2, 0, 32'hFFFFFFFF, 4'hF);
        set_rd(2, 0, 2, 0);
        cycle(1'b1, "zero_bypass");
        we = 1'b0;
        cycle(1'b1, "zero_addr");

        write(0, 4, 32'h1, 4'hF);
        cycle(1'b0, "");
        write(15, 4, 32'h2, 4'hF);
        cycle(1'b0, "");
        write(0, 4, 32'hFFFFFFFF, 4'h0);
        set_rd(0, 4, 15, 4);
        cycle(1'b1, "iso_be0");
        we = 1'b0;
        cycle(1'b1, "isolation");

        for (int k = 0; k < 300; k++) begin
            we    = 1'($urandom_range(0, 1));
            wctx  = 4'($urandom_range(0, 15));
            waddr = 5'($urandom_range(0, 3));
            wdata = $urandom;
            wbe   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) {rctx_a, raddr_a} = {wctx, waddr};
            else set_rd($urandom_range(0, 15), $urandom_range(0, 3), 0, 0);
            if ($urandom_range(0, 3) == 0) {rctx_b, raddr_b} = {wctx, waddr};
            else {rctx_b, raddr_b} = 9'({$urandom_range(0, 15), 5'($urandom_range(0, 3))});
            cycle(1'b1, "rand");
        end
        we = 1'b0;

        // clr_req with a simultaneous write in IDLE; clr_req again while busy.
        check("clr/busy_before", 32'(busy_z), 32'd0);
        clr_req = 1'b1;
        write(1, 1, 32'h12345678, 4'hF);
        set_rd(1, 1, 3, 7);
        cycle(1'b1, "clr_write");
        clr_req = 1'b0;
        we      = 1'b0;
        check("clr/busy_after", 32'(busy_z), 32'd1);
        wait_sweep("clr", 50, 1'b1);
        read_all("clr_all");

        write(6, 6, 32'h0BADF00D, 4'hF);
        cycle(1'b0, "");
        we      = 1'b0;
        clr_req = 1'b1;
        cycle(1'b0, "");
        clr_req = 1'b0;
        for (int k = 0; k < 1000 && ptr_m != 100; k++) cycle(1'b0, "");
        reset = 1'b1;
        cycle(1'b0, "");
        reset = 1'b0;
        check("rst_mid/busy", 32'(busy_z), 32'd1);
        wait_sweep("rst_mid", -1, 1'b0);
        read_all("rst_all");

        for (int k = 0; k < 3; k++) cycle(1'b0, "");
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
